// File: rtl/wavetable_rx.sv
// wavetable_rx: serial wavetable frame receiver with a one-deep holding stage.
// Define WAVETABLE_RX_DENSITY_EN to report the number of 1 bits per frame on OnesCount.
module wavetable_rx #(
  parameter int FRAME_BITS = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  AudioBit,
  input  logic                  BitValid,
  input  logic                  Resync,
  input  logic                  FrameReady,
  output logic [0:FRAME_BITS-1] Wavetable,
  output logic [5:0]            OnesCount,
  output logic                  FrameValid,
  output logic                  Overrun
);

  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                stateQ, stateD;
  logic [IDX_W-1:0]      idxQ, idxD;
  logic [0:FRAME_BITS-1] shiftQ, shiftD;
  logic [0:FRAME_BITS-1] waveQ, waveD;
  logic                  overrunQ, overrunD;
  logic                  sampleEn;
  logic                  frameDone;
  logic                  loadFrame;

  // Resync wins over BitValid, so a bit offered on a resync edge is never sampled.
  assign sampleEn  = BitValid & ~Resync;
  assign frameDone = sampleEn & (idxQ == LAST_IDX);

  always_comb begin
    idxD   = idxQ;
    shiftD = shiftQ;
    if (Resync) begin
      idxD   = '0;
      shiftD = '0;
    end else if (BitValid) begin
      shiftD[idxQ] = AudioBit;
      idxD         = frameDone ? '0 : idxQ + IDX_W'(1);
    end
  end

  always_comb begin
    stateD    = stateQ;
    waveD     = waveQ;
    overrunD  = overrunQ;
    loadFrame = 1'b0;
    case (stateQ)
      EMPTY: begin
        if (frameDone) begin
          stateD    = FULL;
          loadFrame = 1'b1;
        end
      end
      FULL: begin
        if (frameDone) begin
          if (FrameReady) begin
            loadFrame = 1'b1;
          end else begin
            overrunD = 1'b1;
          end
        end else if (FrameReady) begin
          stateD = EMPTY;
        end
      end
      default: stateD = EMPTY;
    endcase
    // shiftD already carries the final bit, so the frame loads on its completing edge.
    if (loadFrame) begin
      waveD = shiftD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ   <= EMPTY;
      idxQ     <= '0;
      shiftQ   <= '0;
      waveQ    <= '0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      idxQ     <= idxD;
      shiftQ   <= shiftD;
      waveQ    <= waveD;
      overrunQ <= overrunD;
    end
  end

  assign Wavetable  = waveQ;
  assign FrameValid = (stateQ == FULL);
  assign Overrun    = overrunQ;

`ifdef WAVETABLE_RX_DENSITY_EN
  logic [5:0] cntQ, cntD;
  logic [5:0] onesQ, onesD;
  logic [5:0] cntWithBit;

  assign cntWithBit = cntQ + {5'd0, AudioBit};

  always_comb begin
    cntD  = cntQ;
    onesD = onesQ;
    if (Resync) begin
      cntD = '0;
    end else if (BitValid) begin
      cntD = frameDone ? 6'd0 : cntWithBit;
    end
    if (loadFrame) begin
      onesD = cntWithBit;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cntQ  <= '0;
      onesQ <= '0;
    end else begin
      cntQ  <= cntD;
      onesQ <= onesD;
    end
  end

  assign OnesCount = onesQ;
`else
  assign OnesCount = 6'd0;
`endif

endmodule
